// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the FSM state encoding and per-digit BCD helpers.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the timer and its driver/display neighbours.
// master drives the controls and slow clock; slave is the timer itself.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  slow_clk;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  pause;
  logic                  tick;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  running;
  logic                  done;

  modport master (
    output slow_clk, load, load_value, start, pause,
    input  tick, count_bcd, running, done
  );

  modport slave (
    input  slow_clk, load, load_value, start, pause,
    output tick, count_bcd, running, done
  );
endinterface

// File: rtl/bcd_countdown_timer_edge_tick_sync.sv
// Synchronises an asynchronous slow clock and emits a one-cycle tick per rising edge.
// Tick appears SYNC_STAGES+1 cycles after the first edge that samples the input high.
module edge_tick_sync
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             hist_q;
  logic                   tick_q;

  // Everything resets high so an input already high at release is not seen as an edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 2'b11;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
      tick_q <= hist_q[0] & ~hist_q[1];
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable, pausable multi-digit BCD countdown driven by ticks derived from a slow clock.
// Reports the live count, a registered running flag and a one-cycle done pulse.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIGITS      = 2
) (
  input  logic                 clock_in,
  input  logic                 reset,
  bcd_countdown_timer_if.slave bus
);

  localparam int W = 4 * DIGITS;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   load_clamped, count_dec;
  logic           running_q;
  logic           done_q, done_d;
  logic           tick;

  edge_tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_tick_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in (bus.slow_clk),
    .tick     (tick)
  );

  always_comb begin
    logic borrow;
    load_clamped = '0;
    count_dec    = '0;
    borrow       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = bcd_clamp(bus.load_value[4*i +: 4]);
      if (!borrow) begin
        count_dec[4*i +: 4] = count_q[4*i +: 4];
      end else if (count_q[4*i +: 4] == BCD_ZERO) begin
        count_dec[4*i +: 4] = BCD_MAX;
      end else begin
        count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
        borrow              = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          count_d = load_clamped;
        end else if (bus.start && !bus.pause && (count_q != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Pause outranks a coincident tick, so the count freezes at its current value.
        if (bus.pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          count_d = count_dec;
          if (count_dec == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (bus.load) begin
          state_d = IDLE;
          count_d = load_clamped;
        end else if (bus.start && !bus.pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.load) begin
          state_d = IDLE;
          count_d = load_clamped;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == RUN);
      done_q    <= done_d;
    end
  end

  assign bus.tick      = tick;
  assign bus.count_bcd = count_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;

endmodule
